ads1675_ctrl: RTL and testbench
===============================

# ads1675_ctrl

Sequencing controller for the ADS1675 capture path. It powers the converter up, configures it, and asserts `start` and `cs_n` in order. It discards the settling samples, then forwards conversion words from the LVDS source stage to the DNCDAQ datapath. A `valid` watchdog restarts the converter on stalls, and after repeated failures the block latches a fault.

## Interface
Parameters:
- `DW`, 24, sample width
- `PWR_CYC`, 4096, clocks from `pown` high to `cs_n` low
- `SETUP_CYC`, 16, clocks `start` is held low before each (re)start
- `DROP`, 50, `in_valid` pulses discarded after each start
- `WD_CYC`, 256, clocks without `in_valid` (in DROP/RUN) that count as a stall
- `MAX_RETRY`, 3, consecutive stall restarts allowed before HALT

Ports:
- `clk` in 1: system clock, shared with the source stage
- `rst` in 1: synchronous, active-high reset
- `en` in 1: level; 1 = run converter, 0 = power down
- `rate_sel` in 3: value for `dr2..dr0`, latched in IDLE or on `cfg_update`
- `fpath_sel` in 1: value for `fpath`, latched with `rate_sel`
- `ll_sel` in 1: value for `ll_cfg`, latched with `rate_sel`
- `cfg_update` in 1: single-cycle pulse that relatches config and restarts; honored in DROP/RUN only
- `in_data` in DW signed: sample from the source stage
- `in_valid` in 1: single-cycle sample strobe from the source stage
- `dr0`, `dr1`, `dr2`, `fpath`, `ll_cfg` out 1 each: registered config pins
- `lvds`, `clk_sel` out 1 each: constant 1 and 0
- `cs_n`, `start`, `pown` out 1 each: registered control pins
- `data` out DW signed: forwarded sample
- `valid` out 1: forwarded-sample strobe
- `state` out 3: current state encoding
- `fault` out 1: sticky stall fault
- `retry_cnt` out 2: consecutive stall restarts

## Operation
State encoding: IDLE=0, PWRUP=1, SETUP=2, DROP=3, RUN=4, HALT=5.

Reset values:
- `state`=IDLE; `pown`=0, `start`=0, `cs_n`=1
- `dr*`, `fpath`, `ll_cfg`=0
- `data`=0, `valid`=0, `fault`=0, `retry_cnt`=0
- all counters 0

Global rule: `en`=0 in any non-IDLE state forces IDLE on the next clock. It takes priority over every other event, and the outputs take their reset values except the config pins, which hold.

States:
- IDLE: with `en`=1, latch `rate_sel`/`fpath_sel`/`ll_sel` onto the pins, set `pown`=1, clear `fault` and `retry_cnt`, go to PWRUP.
- PWRUP: count `PWR_CYC` clocks, then set `cs_n`=0 and go to SETUP.
- SETUP: hold `start`=0 for `SETUP_CYC` clocks, then set `start`=1, clear the drop and watchdog counters, go to DROP.
- DROP: each `in_valid` increments the drop counter and is never forwarded. The pulse that makes the count equal `DROP` is still discarded, and the state moves to RUN on the next clock. `retry_cnt` clears on entry to RUN.
- RUN: `valid`<=`in_valid`; when `in_valid`=1, `data`<=`in_data`. `data` holds otherwise.
- HALT: `start`=0, `cs_n`=1, `pown`=1, `fault`=1. Leaves only via `en`=0.

Watchdog (DROP and RUN):
- Counter clears on `in_valid`, otherwise increments.
- Reaching `WD_CYC-1` with no `in_valid` is a stall.
- Stall with `retry_cnt`<`MAX_RETRY`: `retry_cnt`++, `start`=0, go to SETUP.
- Stall otherwise: go to HALT.

`cfg_update` in DROP/RUN:
- Relatches the config pins, sets `start`=0, goes to SETUP.
- `retry_cnt` is unchanged.
- Same cycle as a stall: `cfg_update` wins; watchdog clears; no retry increment.
- `in_valid` in the same cycle as `cfg_update` or a stall is discarded.

Counters are sized with `$clog2` of their parameter; the drop counter saturates.

## Timing
- Forwarding latency: `in_valid` at cycle n gives `valid` at n+1, one cycle wide; back-to-back strobes forward back-to-back.
- `en` rise at cycle 0 (state IDLE):
  - `pown`=1 at 1
  - `cs_n`=0 at 1+`PWR_CYC`
  - `start`=1 at 1+`PWR_CYC`+`SETUP_CYC`
- Restart (stall or `cfg_update`): `start` is low exactly `SETUP_CYC` clocks, then high.
- `en` fall: `pown`=0, `start`=0, `cs_n`=1, `valid`=0 one clock later.
- `rst` mid-operation: reset values on the next clock regardless of state.
- `lvds`/`clk_sel`: constant from the first clock.

## Test plan
Use PWR_CYC=8, SETUP_CYC=4, DROP=3, WD_CYC=16, MAX_RETRY=2.

- Power-up: `en`=1 at cycle 0 -> `pown`=1 @1, `cs_n`=0 @9, `start`=1 @13, state=DROP; `rate_sel`=3'b101 -> `dr2..dr0`=101.
- Drop/forward: 5 `in_valid` pulses with data 1..5 -> `valid` only for 4 and 5, each one clock after its strobe; state RUN.
- Stall recovery: stop `in_valid` in RUN -> after 16 clocks `start` low for 4 clocks, `retry_cnt`=1, state SETUP then DROP. Then 4 pulses -> 4th forwarded, `retry_cnt`=0.
- Halt: keep `in_valid` silent -> two restarts, then third stall -> state HALT, `fault`=1, `start`=0, `cs_n`=1; `en`=0 -> IDLE with `pown`=0 next clock.
- Priority: `cfg_update` with new `rate_sel`=3'b010 on the same clock as a stall -> `dr`=010, `retry_cnt` unchanged, SETUP. `en`=0 with `cfg_update` -> IDLE, `dr` unchanged.
- Reset mid-RUN: `rst`=1 -> all outputs at reset values the next clock, state IDLE.

Source files
------------

// File: rtl/ads1675_ctrl_if.sv
// ============================================================================
// Module      : ads1675_ctrl_if
// Description : Pin and sample bundle between the ADS1675 controller and its
//               surroundings (converter pins, source stage, DNCDAQ datapath).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ads1675_ctrl_if #(
    parameter int DW = 24
);
    logic                 en;
    logic [2:0]           rate_sel;
    logic                 fpath_sel;
    logic                 ll_sel;
    logic                 cfg_update;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;

    logic                 dr0;
    logic                 dr1;
    logic                 dr2;
    logic                 fpath;
    logic                 ll_cfg;
    logic                 lvds;
    logic                 clk_sel;
    logic                 cs_n;
    logic                 start;
    logic                 pown;
    logic signed [DW-1:0] data;
    logic                 valid;
    logic [2:0]           state;
    logic                 fault;
    logic [1:0]           retry_cnt;

    // master: the controller itself; slave: the environment driving it
    modport master (
        input  en, rate_sel, fpath_sel, ll_sel, cfg_update, in_data, in_valid,
        output dr0, dr1, dr2, fpath, ll_cfg, lvds, clk_sel, cs_n, start, pown,
               data, valid, state, fault, retry_cnt
    );

    modport slave (
        output en, rate_sel, fpath_sel, ll_sel, cfg_update, in_data, in_valid,
        input  dr0, dr1, dr2, fpath, ll_cfg, lvds, clk_sel, cs_n, start, pown,
               data, valid, state, fault, retry_cnt
    );
endinterface

`default_nettype wire

// File: rtl/ads1675_ctrl.sv
// ============================================================================
// Module      : ads1675_ctrl
// Description : ADS1675 power-up/config/start sequencer with settling-sample
//               drop, sample forwarding and a stall watchdog with retry/halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ads1675_ctrl #(
    parameter int DW        = 24,
    parameter int PWR_CYC   = 4096,
    parameter int SETUP_CYC = 16,
    parameter int DROP      = 50,
    parameter int WD_CYC    = 256,
    parameter int MAX_RETRY = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ads1675_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PWRUP = 3'd1,
        ST_SETUP = 3'd2,
        ST_DROP  = 3'd3,
        ST_RUN   = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam int c_TMR_MAX = (PWR_CYC > SETUP_CYC) ? PWR_CYC : SETUP_CYC;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam int c_DROP_W  = (DROP > 0) ? $clog2(DROP + 1) : 1;
    localparam int c_WD_W    = (WD_CYC > 1) ? $clog2(WD_CYC) : 1;

    localparam logic [c_TMR_W-1:0]  c_PWR_LAST   = c_TMR_W'(PWR_CYC - 1);
    localparam logic [c_TMR_W-1:0]  c_SETUP_LAST = c_TMR_W'(SETUP_CYC - 1);
    localparam logic [c_DROP_W-1:0] c_DROP_FULL  = c_DROP_W'(DROP);
    localparam logic [c_WD_W-1:0]   c_WD_LAST    = c_WD_W'(WD_CYC - 1);
    localparam logic [1:0]          c_RETRY_MAX  = 2'(MAX_RETRY);

    state_t               r_state,  w_state_nxt;
    logic [c_TMR_W-1:0]   r_tmr,    w_tmr_nxt;
    logic [c_DROP_W-1:0]  r_drop,   w_drop_nxt;
    logic [c_WD_W-1:0]    r_wd,     w_wd_nxt;
    logic [1:0]           r_retry,  w_retry_nxt;
    logic [4:0]           r_cfg,    w_cfg_nxt;   // {ll_cfg, fpath, dr2, dr1, dr0}
    logic                 r_pown,   w_pown_nxt;
    logic                 r_start,  w_start_nxt;
    logic                 r_cs_n,   w_cs_n_nxt;
    logic                 r_fault,  w_fault_nxt;
    logic                 r_valid,  w_valid_nxt;
    logic signed [DW-1:0] r_data,   w_data_nxt;
    logic                 w_stall;
    logic [4:0]           w_cfg_in;

    assign w_cfg_in = {bus.ll_sel, bus.fpath_sel, bus.rate_sel};

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_drop_nxt  = r_drop;
        w_wd_nxt    = r_wd;
        w_retry_nxt = r_retry;
        w_cfg_nxt   = r_cfg;
        w_pown_nxt  = r_pown;
        w_start_nxt = r_start;
        w_cs_n_nxt  = r_cs_n;
        w_fault_nxt = r_fault;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_stall     = 1'b0;

        if ((r_state != ST_IDLE) && !bus.en) begin
            // Power-down overrides everything; config pins keep their value
            w_state_nxt = ST_IDLE;
            w_tmr_nxt   = '0;
            w_drop_nxt  = '0;
            w_wd_nxt    = '0;
            w_retry_nxt = '0;
            w_pown_nxt  = 1'b0;
            w_start_nxt = 1'b0;
            w_cs_n_nxt  = 1'b1;
            w_fault_nxt = 1'b0;
            w_data_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        w_cfg_nxt   = w_cfg_in;
                        w_pown_nxt  = 1'b1;
                        w_fault_nxt = 1'b0;
                        w_retry_nxt = '0;
                        w_tmr_nxt   = '0;
                        w_state_nxt = ST_PWRUP;
                    end
                end
                ST_PWRUP: begin
                    if (r_tmr == c_PWR_LAST) begin
                        w_tmr_nxt   = '0;
                        w_cs_n_nxt  = 1'b0;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_tmr == c_SETUP_LAST) begin
                        w_tmr_nxt   = '0;
                        w_start_nxt = 1'b1;
                        w_drop_nxt  = '0;
                        w_wd_nxt    = '0;
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                ST_DROP, ST_RUN: begin
                    w_stall = !bus.in_valid && (r_wd == c_WD_LAST);
                    if (bus.cfg_update) begin
                        w_cfg_nxt   = w_cfg_in;
                        w_start_nxt = 1'b0;
                        w_tmr_nxt   = '0;
                        w_wd_nxt    = '0;
                        w_state_nxt = ST_SETUP;
                    end else if (w_stall) begin
                        w_start_nxt = 1'b0;
                        w_tmr_nxt   = '0;
                        w_wd_nxt    = '0;
                        if (r_retry < c_RETRY_MAX) begin
                            w_retry_nxt = r_retry + 2'd1;
                            w_state_nxt = ST_SETUP;
                        end else begin
                            w_cs_n_nxt  = 1'b1;
                            w_fault_nxt = 1'b1;
                            w_state_nxt = ST_HALT;
                        end
                    end else begin
                        w_wd_nxt = bus.in_valid ? '0 : r_wd + 1'b1;
                        if (r_state == ST_DROP) begin
                            if (bus.in_valid && (r_drop != c_DROP_FULL)) begin
                                w_drop_nxt = r_drop + 1'b1;
                                // The pulse completing the count is still dropped
                                if ((r_drop + 1'b1) == c_DROP_FULL) begin
                                    w_retry_nxt = '0;
                                    w_state_nxt = ST_RUN;
                                end
                            end
                        end else begin
                            w_valid_nxt = bus.in_valid;
                            if (bus.in_valid) begin
                                w_data_nxt = bus.in_data;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    w_start_nxt = 1'b0;
                    w_cs_n_nxt  = 1'b1;
                    w_pown_nxt  = 1'b1;
                    w_fault_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_drop  <= '0;
            r_wd    <= '0;
            r_retry <= '0;
            r_cfg   <= '0;
            r_pown  <= 1'b0;
            r_start <= 1'b0;
            r_cs_n  <= 1'b1;
            r_fault <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_drop  <= w_drop_nxt;
            r_wd    <= w_wd_nxt;
            r_retry <= w_retry_nxt;
            r_cfg   <= w_cfg_nxt;
            r_pown  <= w_pown_nxt;
            r_start <= w_start_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_fault <= w_fault_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.dr0       = r_cfg[0];
    assign bus.dr1       = r_cfg[1];
    assign bus.dr2       = r_cfg[2];
    assign bus.fpath     = r_cfg[3];
    assign bus.ll_cfg    = r_cfg[4];
    assign bus.lvds      = 1'b1;
    assign bus.clk_sel   = 1'b0;
    assign bus.cs_n      = r_cs_n;
    assign bus.start     = r_start;
    assign bus.pown      = r_pown;
    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.state     = r_state;
    assign bus.fault     = r_fault;
    assign bus.retry_cnt = r_retry;

endmodule

`default_nettype wire

// File: tb/tb_ads1675_ctrl.sv
// ============================================================================
// Module      : tb_ads1675_ctrl
// Description : Directed self-checking bench for ads1675_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ads1675_ctrl;

    localparam int c_DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    ads1675_ctrl_if #(.DW(c_DW)) bus ();

    ads1675_ctrl #(
        .DW        (c_DW),
        .PWR_CYC   (8),
        .SETUP_CYC (4),
        .DROP      (3),
        .WD_CYC    (16),
        .MAX_RETRY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe then one idle cycle; checks forwarding right after the strobe edge
    task automatic pulse(input int d, input logic exp_valid);
        bus.in_valid = 1'b1;
        bus.in_data  = c_DW'(d);
        tick(1);
        chk("pulse_valid", 32'(bus.valid), 32'(exp_valid));
        if (exp_valid) chk("pulse_data", 32'(bus.data), 32'(d));
        bus.in_valid = 1'b0;
        tick(1);
        chk("gap_valid", 32'(bus.valid), 32'd0);
    endtask

    function automatic logic [2:0] dr();
        return {bus.dr2, bus.dr1, bus.dr0};
    endfunction

    initial begin
        bus.en         = 1'b0;
        bus.rate_sel   = 3'b000;
        bus.fpath_sel  = 1'b0;
        bus.ll_sel     = 1'b0;
        bus.cfg_update = 1'b0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;

        tick(2);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pown",  32'(bus.pown), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_cs_n",  32'(bus.cs_n), 32'd1);
        chk("rst_dr",    32'(dr()), 32'd0);
        chk("rst_lvds",  32'({bus.lvds, bus.clk_sel}), 32'b10);
        chk("rst_misc",  32'({bus.valid, bus.fault, bus.retry_cnt}), 32'd0);

        // Power-up sequence
        rst = 1'b0;
        bus.rate_sel  = 3'b101;
        bus.fpath_sel = 1'b1;
        tick(1);
        chk("idle_hold", 32'(bus.state), 32'd0);
        bus.en = 1'b1;
        tick(1);
        chk("pu_pown1",  32'(bus.pown), 32'd1);
        chk("pu_state1", 32'(bus.state), 32'd1);
        chk("pu_dr",     32'({bus.ll_cfg, bus.fpath, dr()}), 32'b01101);
        bus.rate_sel = 3'b000;
        tick(7);
        chk("pu_cs8",    32'(bus.cs_n), 32'd1);
        tick(1);
        chk("pu_cs9",    32'(bus.cs_n), 32'd0);
        chk("pu_state9", 32'(bus.state), 32'd2);
        tick(3);
        chk("pu_start12", 32'(bus.start), 32'd0);
        tick(1);
        chk("pu_start13", 32'(bus.start), 32'd1);
        chk("pu_state13", 32'(bus.state), 32'd3);
        chk("pu_dr_hold", 32'(dr()), 32'b101);

        // Drop three settling samples, forward the rest
        pulse(1, 1'b0);
        pulse(2, 1'b0);
        pulse(3, 1'b0);
        chk("run_state", 32'(bus.state), 32'd4);
        pulse(4, 1'b1);
        chk("data_hold", 32'(bus.data), 32'd4);
        pulse(5, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'd6;
        tick(1);
        chk("b2b_6", 32'({bus.valid, bus.data}), {8'd1, 24'd6});
        bus.in_data  = 24'd7;
        tick(1);
        chk("b2b_7", 32'({bus.valid, bus.data}), {8'd1, 24'd7});
        bus.in_valid = 1'b0;
        tick(1);
        chk("b2b_end", 32'({bus.valid, bus.data}), {8'd0, 24'd7});

        // Stall recovery: 16 silent cycles after the last strobe
        tick(14);
        chk("wd_pre_start", 32'(bus.start), 32'd1);
        chk("wd_pre_state", 32'(bus.state), 32'd4);
        tick(1);
        chk("wd_start",  32'(bus.start), 32'd0);
        chk("wd_state",  32'(bus.state), 32'd2);
        chk("wd_retry",  32'(bus.retry_cnt), 32'd1);
        tick(3);
        chk("wd_start_low", 32'(bus.start), 32'd0);
        tick(1);
        chk("wd_restart", 32'({bus.start, bus.state}), {28'd0, 1'b1, 3'd3});
        pulse(11, 1'b0);
        chk("retry_drop", 32'(bus.retry_cnt), 32'd1);
        pulse(12, 1'b0);
        pulse(13, 1'b0);
        chk("retry_clr", 32'(bus.retry_cnt), 32'd0);
        pulse(14, 1'b1);

        // Silent converter: two restarts, then halt
        tick(15);
        chk("h_stall1", 32'({bus.state, bus.retry_cnt}), {27'd0, 3'd2, 2'd1});
        tick(4);
        chk("h_drop1", 32'(bus.state), 32'd3);
        tick(16);
        chk("h_stall2", 32'({bus.state, bus.retry_cnt}), {27'd0, 3'd2, 2'd2});
        tick(4);
        tick(15);
        chk("h_pre", 32'(bus.state), 32'd3);
        tick(1);
        chk("h_state", 32'(bus.state), 32'd5);
        chk("h_pins",  32'({bus.fault, bus.start, bus.cs_n, bus.pown}), 32'b1011);
        tick(5);
        chk("h_stay",  32'(bus.state), 32'd5);
        bus.en = 1'b0;
        tick(1);
        chk("h_off", 32'({bus.state, bus.pown, bus.fault, bus.cs_n, bus.retry_cnt}),
            {25'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0});

        // cfg_update coinciding with a stall in DROP (retry_cnt=1)
        bus.rate_sel = 3'b101;
        bus.en = 1'b1;
        tick(13);
        pulse(21, 1'b0);
        pulse(22, 1'b0);
        pulse(23, 1'b0);
        tick(15);
        chk("p_stall", 32'({bus.state, bus.retry_cnt}), {27'd0, 3'd2, 2'd1});
        tick(4);
        tick(15);
        bus.cfg_update = 1'b1;
        bus.rate_sel   = 3'b010;
        tick(1);
        bus.cfg_update = 1'b0;
        chk("p_dr",    32'(dr()), 32'b010);
        chk("p_retry", 32'(bus.retry_cnt), 32'd1);
        chk("p_state", 32'({bus.state, bus.start}), {28'd0, 3'd2, 1'b0});
        tick(4);
        chk("p_restart", 32'({bus.state, bus.start}), {28'd0, 3'd3, 1'b1});
        bus.en         = 1'b0;
        bus.cfg_update = 1'b1;
        bus.rate_sel   = 3'b111;
        tick(1);
        bus.cfg_update = 1'b0;
        chk("p_en_state", 32'({bus.state, bus.pown}), 32'd0);
        chk("p_en_dr",    32'(dr()), 32'b010);

        // Reset mid-RUN with a strobe pending
        bus.rate_sel = 3'b101;
        bus.en = 1'b1;
        tick(13);
        pulse(31, 1'b0);
        pulse(32, 1'b0);
        pulse(33, 1'b0);
        pulse(34, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'd35;
        rst = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        chk("r_state", 32'(bus.state), 32'd0);
        chk("r_out",   32'({bus.valid, bus.data}), 32'd0);
        chk("r_pins",  32'({bus.pown, bus.start, bus.cs_n, bus.fault, bus.retry_cnt, dr()}),
            32'b0010_00_000);
        rst = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
